// File: rtl/systolic_mm_engine.sv
// NxN output-stationary systolic matrix-multiply engine with host-addressed A/B/C storage and an internal run FSM.
// Define SYSTOLIC_SAT_EN to saturate C reads to the signed DW range; by default C reads wrap to the low DW bits.
module systolic_mm_engine #(
    parameter int N    = 8,
    parameter int DW   = 16,
    parameter int AW   = 2 + 2 * $clog2(N),
    parameter int ACCW = 2 * DW + $clog2(N)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic          WRITE,
    input  logic          RD_EN,
    input  logic [AW-1:0] ADDR,
    input  logic [DW-1:0] DATA_IN,
    output logic [DW-1:0] DATA_OUT,
    output logic          RD_VALID,
    input  logic          START,
    output logic          BUSY,
    output logic          DONE
);

    localparam int IW     = AW - 2;
    localparam int NN     = N * N;
    localparam int TW     = $clog2(3 * N);
    localparam int T_LAST = 3 * N - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [TW-1:0] t_reg, t_next;
    logic          clear;
    logic          stream;

    logic [1:0]    region;
    logic [IW-1:0] idx;

    assign region = ADDR[AW-1:AW-2];
    assign idx    = ADDR[IW-1:0];

    // ---------------------------------------------------------------
    // Run FSM
    // ---------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            t_reg     <= '0;
        end else if (EN) begin
            state_reg <= state_next;
            t_reg     <= t_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        t_next     = t_reg;
        clear      = 1'b0;
        stream     = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (START) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                clear      = 1'b1;
                BUSY       = 1'b1;
                t_next     = '0;
                state_next = STREAM;
            end
            STREAM: begin
                stream = 1'b1;
                BUSY   = 1'b1;
                if (int'(t_reg) == T_LAST) begin
                    state_next = FIN;
                end else begin
                    t_next = t_reg + TW'(1);
                end
            end
            FIN: begin
                DONE       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Operand storage: register arrays, since every row and column
    // edge reads its own element in the same cycle.
    // ---------------------------------------------------------------
    logic [DW-1:0] a_mem [NN];
    logic [DW-1:0] b_mem [NN];

    always_ff @(posedge CLK) begin
        if (!RST && EN && WRITE && !BUSY) begin
            if (region == 2'b00) begin
                a_mem[idx] <= DATA_IN;
            end else if (region == 2'b01) begin
                b_mem[idx] <= DATA_IN;
            end
        end
    end

    // Skewed edge feed: row i sees A[i][k] and column j sees B[k][j] at t = edge + k.
    logic [DW-1:0] feed_a [N];
    logic [DW-1:0] feed_b [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            feed_a[i] = '0;
            feed_b[i] = '0;
            for (int k = 0; k < N; k++) begin
                if (int'(t_reg) == i + k) begin
                    feed_a[i] = a_mem[IW'(i * N + k)];
                    feed_b[i] = b_mem[IW'(k * N + i)];
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Processing-element grid
    // ---------------------------------------------------------------
    logic [DW-1:0]   a_out   [NN];
    logic [DW-1:0]   b_out   [NN];
    logic [ACCW-1:0] acc_out [NN];

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                logic [DW-1:0]   a_in;
                logic [DW-1:0]   b_in;
                logic [DW-1:0]   a_reg;
                logic [DW-1:0]   b_reg;
                logic [2*DW-1:0] prod;
                logic [ACCW-1:0] acc_reg;

                if (gj == 0) begin : g_a_edge
                    assign a_in = feed_a[gi];
                end else begin : g_a_fwd
                    assign a_in = a_out[gi * N + gj - 1];
                end

                if (gi == 0) begin : g_b_edge
                    assign b_in = feed_b[gj];
                end else begin : g_b_fwd
                    assign b_in = b_out[(gi - 1) * N + gj];
                end

                // Sign-extended operands make the truncated product the exact signed result.
                assign prod = {{DW{a_in[DW-1]}}, a_in} * {{DW{b_in[DW-1]}}, b_in};

                always_ff @(posedge CLK) begin
                    if (RST) begin
                        a_reg   <= '0;
                        b_reg   <= '0;
                        acc_reg <= '0;
                    end else if (EN) begin
                        if (clear) begin
                            a_reg   <= '0;
                            b_reg   <= '0;
                            acc_reg <= '0;
                        end else if (stream) begin
                            a_reg   <= a_in;
                            b_reg   <= b_in;
                            acc_reg <= acc_reg + {{(ACCW - 2 * DW){prod[2*DW-1]}}, prod};
                        end
                    end
                end

                assign a_out[gi * N + gj]   = a_reg;
                assign b_out[gi * N + gj]   = b_reg;
                assign acc_out[gi * N + gj] = acc_reg;
            end
        end
    endgenerate

    // ---------------------------------------------------------------
    // Host read path
    // ---------------------------------------------------------------
    logic [ACCW-1:0] acc_sel;
    logic [DW-1:0]   c_data;
    logic [DW-1:0]   rd_data;

    assign acc_sel = acc_out[idx];

`ifdef SYSTOLIC_SAT_EN
    logic [ACCW-DW:0] acc_top;
    assign acc_top = acc_sel[ACCW-1:DW-1];

    // In range only when every bit above the DW-bit sign matches it.
    always_comb begin
        c_data = acc_sel[DW-1:0];
        if (acc_top != '0 && acc_top != '1) begin
            c_data = acc_sel[ACCW-1] ? {1'b1, {(DW - 1){1'b0}}} : {1'b0, {(DW - 1){1'b1}}};
        end
    end
`else
    always_comb begin
        c_data = acc_sel[DW-1:0];
    end
`endif

    always_comb begin
        rd_data = '0;
        case (region)
            2'b00:   rd_data = a_mem[idx];
            2'b01:   rd_data = b_mem[idx];
            2'b10:   rd_data = c_data;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            DATA_OUT <= '0;
            RD_VALID <= 1'b0;
        end else if (EN) begin
            RD_VALID <= RD_EN;
            if (RD_EN) begin
                DATA_OUT <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Scoreboard bench for systolic_mm_engine (N=8, DW=16); expected C comes from a behavioural matrix product.
// Honours SYSTOLIC_SAT_EN the same way the design does when modelling C reads.
module tb_systolic_mm_engine;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b1;
    logic        WRITE = 1'b0;
    logic        RD_EN = 1'b0;
    logic [7:0]  ADDR = '0;
    logic [15:0] DATA_IN = '0;
    logic [15:0] DATA_OUT;
    logic        RD_VALID;
    logic        START = 1'b0;
    logic        BUSY;
    logic        DONE;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } rd_t;

    rd_t         exp_q[$];
    logic [15:0] got_q[$];
    bit          cap_en = 1'b0;

    logic signed [15:0] ma [8][8];
    logic signed [15:0] mb [8][8];

    systolic_mm_engine #(.N(8), .DW(16)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .WRITE(WRITE), .RD_EN(RD_EN),
        .ADDR(ADDR), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .RD_VALID(RD_VALID),
        .START(START), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (cap_en && RD_VALID) got_q.push_back(DATA_OUT);
    end

    function automatic logic [15:0] model_c(int i, int j);
        longint acc = 0;
        for (int k = 0; k < 8; k++) acc += longint'(ma[i][k]) * longint'(mb[k][j]);
`ifdef SYSTOLIC_SAT_EN
        if (acc > 32767) return 16'h7fff;
        if (acc < -32768) return 16'h8000;
`endif
        return 16'(acc);
    endfunction

    task automatic write_word(input logic [7:0] a, input logic [15:0] d);
        @(negedge CLK);
        WRITE = 1'b1; ADDR = a; DATA_IN = d;
        @(negedge CLK);
        WRITE = 1'b0;
    endtask

    task automatic load_ab();
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin
                write_word(8'(i * 8 + k), ma[i][k]);
                write_word(8'(64 + i * 8 + k), mb[i][k]);
            end
    endtask

    task automatic queue_c_reads();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) exp_q.push_back('{8'(128 + i * 8 + j), model_c(i, j)});
    endtask

    task automatic run_reads();
        got_q.delete();
        cap_en = 1'b1;
        foreach (exp_q[k]) begin
            @(negedge CLK);
            RD_EN = 1'b1; ADDR = exp_q[k].addr;
        end
        @(negedge CLK);
        RD_EN = 1'b0;
        @(negedge CLK);
        cap_en = 1'b0;
    endtask

    task automatic start_and_wait(output int dc);
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        dc = 0;
        for (int c = 1; c <= 100 && dc == 0; c++) begin
            if (DONE) dc = c;
            else @(negedge CLK);
        end
        @(negedge CLK);
        $display("run: DONE at cycle %0d", dc);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        checks += 4;
        if (DATA_OUT !== 16'h0) begin errors++; $display("FAIL reset_data_out got=%h want=0000", DATA_OUT); end
        if (RD_VALID !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b want=0", RD_VALID); end
        if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", BUSY); end
        if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", DONE); end
        RST = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_identity();
        int dc;
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin
                ma[i][k] = 16'(k + 1);
                mb[i][k] = (i == k) ? 16'sd1 : 16'sd0;
            end
        load_ab();
        start_and_wait(dc);
        checks++;
        if (dc != 25) begin errors++; $display("FAIL identity_done_cycle got=%0d want=25", dc); end
        @(negedge CLK);
        RD_EN = 1'b1; ADDR = 8'(128 + 3 * 8 + 5);
        @(negedge CLK);
        RD_EN = 1'b0;
        checks += 3;
        if (RD_VALID !== 1'b1) begin errors++; $display("FAIL latency_valid got=%b want=1", RD_VALID); end
        if (DATA_OUT !== 16'd6) begin errors++; $display("FAIL latency_data got=%h want=0006", DATA_OUT); end
        @(negedge CLK);
        if (RD_VALID !== 1'b0) begin errors++; $display("FAIL latency_valid_drop got=%b want=0", RD_VALID); end
        queue_c_reads();
        run_reads();
        foreach (exp_q[k]) begin
            checks++;
            if (k >= got_q.size()) begin errors++; $display("FAIL identity_c addr=%0d got=none want=%h", exp_q[k].addr, exp_q[k].data); end
            else if (got_q[k] !== exp_q[k].data) begin errors++; $display("FAIL identity_c addr=%0d got=%h want=%h", exp_q[k].addr, got_q[k], exp_q[k].data); end
            else $display("identity read addr=%0d data=%h", exp_q[k].addr, got_q[k]);
        end
        exp_q.delete();
    endtask

    // Dense data (every C = 204) with a second START at cycle 5 that must be ignored.
    task automatic test_timing();
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 8; j++) mb[k][j] = 16'(k + 1);
        load_ab();
        @(negedge CLK);
        START = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge CLK);
            START = (c == 5);
            checks += 2;
            if (BUSY !== (c >= 1 && c <= 24)) begin errors++; $display("FAIL timing_busy cycle=%0d got=%b want=%b", c, BUSY, (c >= 1 && c <= 24)); end
            if (DONE !== (c == 25)) begin errors++; $display("FAIL timing_done cycle=%0d got=%b want=%b", c, DONE, (c == 25)); end
        end
        START = 1'b0;
        $display("timing: busy/done window checked");
        queue_c_reads();
        run_reads();
        foreach (exp_q[k]) begin
            checks++;
            if (k >= got_q.size()) begin errors++; $display("FAIL dense_c addr=%0d got=none want=%h", exp_q[k].addr, exp_q[k].data); end
            else if (got_q[k] !== exp_q[k].data) begin errors++; $display("FAIL dense_c addr=%0d got=%h want=%h", exp_q[k].addr, got_q[k], exp_q[k].data); end
            else $display("dense read addr=%0d data=%h", exp_q[k].addr, got_q[k]);
        end
        exp_q.delete();
    endtask

    task automatic test_stall();
        @(negedge CLK);
        START = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            @(negedge CLK);
            START = 1'b0;
            checks += 2;
            if (BUSY !== (c >= 1 && c <= 27)) begin errors++; $display("FAIL stall_busy cycle=%0d got=%b want=%b", c, BUSY, (c >= 1 && c <= 27)); end
            if (DONE !== (c == 28)) begin errors++; $display("FAIL stall_done cycle=%0d got=%b want=%b", c, DONE, (c == 28)); end
            EN = !(c >= 10 && c <= 12);
        end
        EN = 1'b1;
        $display("stall: busy/done window checked");
        queue_c_reads();
        run_reads();
        foreach (exp_q[k]) begin
            checks++;
            if (k >= got_q.size()) begin errors++; $display("FAIL stall_c addr=%0d got=none want=%h", exp_q[k].addr, exp_q[k].data); end
            else if (got_q[k] !== exp_q[k].data) begin errors++; $display("FAIL stall_c addr=%0d got=%h want=%h", exp_q[k].addr, got_q[k], exp_q[k].data); end
            else $display("stall read addr=%0d data=%h", exp_q[k].addr, got_q[k]);
        end
        exp_q.delete();
    endtask

    task automatic test_access();
        int dc = 0;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        WRITE = 1'b1; ADDR = 8'd10; DATA_IN = 16'h1234;
        @(negedge CLK);
        WRITE = 1'b0;
        for (int c = 2; c <= 100 && dc == 0; c++) begin
            if (DONE) dc = c;
            else @(negedge CLK);
        end
        checks++;
        if (dc != 25) begin errors++; $display("FAIL access_done_cycle got=%0d want=25", dc); end
        write_word(8'd130, 16'h1234);
        exp_q.push_back('{8'd10, ma[1][2]});
        exp_q.push_back('{8'd130, model_c(0, 2)});
        exp_q.push_back('{8'd200, 16'h0000});
        exp_q.push_back('{8'd64, mb[0][0]});
        run_reads();
        foreach (exp_q[k]) begin
            checks++;
            if (k >= got_q.size()) begin errors++; $display("FAIL access_rd addr=%0d got=none want=%h", exp_q[k].addr, exp_q[k].data); end
            else if (got_q[k] !== exp_q[k].data) begin errors++; $display("FAIL access_rd addr=%0d got=%h want=%h", exp_q[k].addr, got_q[k], exp_q[k].data); end
            else $display("access read addr=%0d data=%h", exp_q[k].addr, got_q[k]);
        end
        exp_q.delete();
        @(negedge CLK);
        WRITE = 1'b1; RD_EN = 1'b1; ADDR = 8'd10; DATA_IN = 16'h0055;
        @(negedge CLK);
        WRITE = 1'b0;
        checks++;
        if (DATA_OUT !== ma[1][2]) begin errors++; $display("FAIL rw_same_old got=%h want=%h", DATA_OUT, ma[1][2]); end
        @(negedge CLK);
        RD_EN = 1'b0;
        checks++;
        if (DATA_OUT !== 16'h0055) begin errors++; $display("FAIL rw_same_new got=%h want=0055", DATA_OUT); end
        $display("access: same-address read/write checked");
        write_word(8'd10, ma[1][2]);
    endtask

    task automatic test_reset_midrun();
        int dc;
        bit seen = 1'b0;
        @(negedge CLK);
        START = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            START = 1'b0;
            if (c == 9) begin
                checks++;
                if (BUSY !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b want=1", BUSY); end
                RST = 1'b1;
            end
            if (c == 10) begin
                checks += 2;
                if (BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", BUSY); end
                if (DONE !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b want=0", DONE); end
                RST = 1'b0;
            end
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (DONE) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midrst_stray_done got=1 want=0"); end
        for (int a = 128; a < 192; a++) exp_q.push_back('{8'(a), 16'h0000});
        run_reads();
        foreach (exp_q[k]) begin
            checks++;
            if (k >= got_q.size()) begin errors++; $display("FAIL midrst_c addr=%0d got=none want=%h", exp_q[k].addr, exp_q[k].data); end
            else if (got_q[k] !== exp_q[k].data) begin errors++; $display("FAIL midrst_c addr=%0d got=%h want=%h", exp_q[k].addr, got_q[k], exp_q[k].data); end
            else $display("midrst read addr=%0d data=%h", exp_q[k].addr, got_q[k]);
        end
        exp_q.delete();
        start_and_wait(dc);
        checks++;
        if (dc != 25) begin errors++; $display("FAIL rerun_done_cycle got=%0d want=25", dc); end
        queue_c_reads();
        run_reads();
        foreach (exp_q[k]) begin
            checks++;
            if (k >= got_q.size()) begin errors++; $display("FAIL rerun_c addr=%0d got=none want=%h", exp_q[k].addr, exp_q[k].data); end
            else if (got_q[k] !== exp_q[k].data) begin errors++; $display("FAIL rerun_c addr=%0d got=%h want=%h", exp_q[k].addr, got_q[k], exp_q[k].data); end
            else $display("rerun read addr=%0d data=%h", exp_q[k].addr, got_q[k]);
        end
        exp_q.delete();
    endtask

    // fill: 0 = random signed full range, 1 = every operand 0x7FFF.
    task automatic test_signed(input int fill);
        int dc;
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin
                ma[i][k] = (fill == 1) ? 16'sh7fff : 16'($urandom);
                mb[i][k] = (fill == 1) ? 16'sh7fff : 16'($urandom);
            end
        load_ab();
        start_and_wait(dc);
        checks++;
        if (dc != 25) begin errors++; $display("FAIL signed_done_cycle fill=%0d got=%0d want=25", fill, dc); end
        queue_c_reads();
        run_reads();
        foreach (exp_q[k]) begin
            checks++;
            if (k >= got_q.size()) begin errors++; $display("FAIL signed_c fill=%0d addr=%0d got=none want=%h", fill, exp_q[k].addr, exp_q[k].data); end
            else if (got_q[k] !== exp_q[k].data) begin errors++; $display("FAIL signed_c fill=%0d addr=%0d got=%h want=%h", fill, exp_q[k].addr, got_q[k], exp_q[k].data); end
            else $display("signed read fill=%0d addr=%0d data=%h", fill, exp_q[k].addr, got_q[k]);
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_timing();
        test_stall();
        test_access();
        test_reset_midrun();
        test_signed(0);
        test_signed(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
